// File: rtl/mem_write_arbiter_pkg.sv
// Shared definitions for the memory write-port arbiter and its target decode.
package mem_write_arbiter_pkg;

  // Address bits that select the write target.
  localparam int unsigned DMEM_SEL_BIT = 28;
  localparam int unsigned IMEM_SEL_BIT = 29;
  localparam int unsigned MMIO_SEL_BIT = 31;

  // Arbiter ownership states.
  typedef enum logic [0:0] {
    ARB_IDLE      = 1'b0,
    ARB_DMA_BURST = 1'b1
  } arb_state_e;

  // One write beat as presented by either requester.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_beat_t;

  // Increment that sticks at lim.
  function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic [7:0] lim);
    return (val >= lim) ? lim : val + 8'd1;
  endfunction

endpackage

// File: rtl/mem_write_arbiter_decode.sv
// Combinational target decode: select bits and byte mask -> per-target enables.
// Shared with the load path, so it holds no state.
module write_port_decode (
  input  logic       dmem_sel_i,
  input  logic       imem_sel_i,
  input  logic       mmio_sel_i,
  input  logic [3:0] mask_i,
  output logic [3:0] dmem_we_o,
  output logic [3:0] imem_we_o,
  output logic       mmio_we_o,
  output logic       drop_err_o
);

  // MMIO wins exclusively; dmem and imem may both be hit by one beat.
  always_comb begin
    dmem_we_o  = 4'b0000;
    imem_we_o  = 4'b0000;
    mmio_we_o  = 1'b0;
    drop_err_o = 1'b0;
    if (mmio_sel_i) begin
      mmio_we_o = |mask_i;
    end else begin
      dmem_we_o  = dmem_sel_i ? mask_i : 4'b0000;
      imem_we_o  = imem_sel_i ? mask_i : 4'b0000;
      drop_err_o = !dmem_sel_i && !imem_sel_i && (|mask_i);
    end
  end

endmodule

// File: rtl/mem_write_arbiter.sv
// Arbitrates the shared memory write port between the CPU store path (priority)
// and the DMA engine (bounded bursts, starvation guarantee). The winning beat is
// registered and decoded into dmem/imem/mmio enables one cycle later.
module mem_write_arbiter #(
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_valid_i,
  output logic        cpu_ready_o,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_mask_i,
  input  logic        dma_valid_i,
  output logic        dma_ready_o,
  input  logic        dma_last_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_data_i,
  input  logic [3:0]  dma_mask_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_din_o,
  output logic [3:0]  dmem_we_o,
  output logic [3:0]  imem_we_o,
  output logic        mmio_we_o,
  output logic        drop_err_o,
  output logic        grant_dma_o
);
  import mem_write_arbiter_pkg::*;

  localparam logic [7:0] MaxBurst    = 8'(MAX_BURST);
  localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);

  arb_state_e  state_q, state_d;
  logic [7:0]  burst_q, burst_d;
  logic [7:0]  starve_q, starve_d;
  logic [7:0]  burst_inc;
  logic        starving;
  logic        cpu_ready, dma_ready, accept;

  wr_beat_t    cpu_beat, dma_beat, sel_beat;

  logic [31:0] mem_addr_q, mem_din_q;
  logic [3:0]  dmem_we_q, imem_we_q;
  logic        mmio_we_q, drop_err_q;

  logic [3:0]  dec_dmem_we, dec_imem_we;
  logic        dec_mmio_we, dec_drop_err;

  assign starving = (starve_q == StarveLimit);

  // Grant decision and burst bookkeeping.
  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    burst_inc = burst_q + 8'd1;
    cpu_ready = 1'b0;
    dma_ready = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // A starving DMA only overrides the CPU when it is actually requesting.
        if (cpu_valid_i && !(starving && dma_valid_i)) begin
          cpu_ready = 1'b1;
        end else if (dma_valid_i) begin
          dma_ready = 1'b1;
          if (dma_last_i || ((MaxBurst == 8'd1) && cpu_valid_i)) begin
            state_d = ARB_IDLE;
            burst_d = 8'd0;
          end else if (MaxBurst == 8'd1) begin
            state_d = ARB_DMA_BURST;
            burst_d = 8'd0;
          end else begin
            state_d = ARB_DMA_BURST;
            burst_d = 8'd1;
          end
        end
      end
      ARB_DMA_BURST: begin
        if (dma_valid_i) begin
          dma_ready = 1'b1;
          if (dma_last_i) begin
            state_d = ARB_IDLE;
            burst_d = 8'd0;
          end else if (burst_inc == MaxBurst) begin
            // Yield only if the CPU is waiting; otherwise start a fresh window.
            burst_d = 8'd0;
            if (cpu_valid_i) state_d = ARB_IDLE;
          end else begin
            burst_d = burst_inc;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        burst_d = 8'd0;
      end
    endcase
  end

  // Count cycles DMA is left waiting; any accept or idle DMA clears it.
  always_comb begin
    starve_d = 8'd0;
    if (dma_valid_i && !dma_ready) starve_d = sat_inc(starve_q, StarveLimit);
  end

  // Select the winning beat for the output register.
  always_comb begin
    cpu_beat = '{addr: cpu_addr_i, data: cpu_data_i, mask: cpu_mask_i};
    dma_beat = '{addr: dma_addr_i, data: dma_data_i, mask: dma_mask_i};
    sel_beat = dma_ready ? dma_beat : cpu_beat;
    accept   = cpu_ready || dma_ready;
  end

  write_port_decode u_decode (
    .dmem_sel_i (sel_beat.addr[DMEM_SEL_BIT]),
    .imem_sel_i (sel_beat.addr[IMEM_SEL_BIT]),
    .mmio_sel_i (sel_beat.addr[MMIO_SEL_BIT]),
    .mask_i     (sel_beat.mask),
    .dmem_we_o  (dec_dmem_we),
    .imem_we_o  (dec_imem_we),
    .mmio_we_o  (dec_mmio_we),
    .drop_err_o (dec_drop_err)
  );

  // Arbiter state and counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      burst_q  <= 8'd0;
      starve_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      starve_q <= starve_d;
    end
  end

  // Output register: enables pulse for one cycle, address/data hold between beats.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_addr_q <= 32'd0;
      mem_din_q  <= 32'd0;
      dmem_we_q  <= 4'd0;
      imem_we_q  <= 4'd0;
      mmio_we_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end else if (accept) begin
      mem_addr_q <= sel_beat.addr;
      mem_din_q  <= sel_beat.data;
      dmem_we_q  <= dec_dmem_we;
      imem_we_q  <= dec_imem_we;
      mmio_we_q  <= dec_mmio_we;
      drop_err_q <= dec_drop_err;
    end else begin
      dmem_we_q  <= 4'd0;
      imem_we_q  <= 4'd0;
      mmio_we_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end
  end

  assign cpu_ready_o = cpu_ready;
  assign dma_ready_o = dma_ready;
  assign mem_addr_o  = mem_addr_q;
  assign mem_din_o   = mem_din_q;
  assign dmem_we_o   = dmem_we_q;
  assign imem_we_o   = imem_we_q;
  assign mmio_we_o   = mmio_we_q;
  assign drop_err_o  = drop_err_q;
  assign grant_dma_o = (state_q == ARB_DMA_BURST);

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed bench for mem_write_arbiter (MAX_BURST=8, STARVE_LIMIT=16).
module tb_mem_write_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cpu_valid_i, cpu_ready_o;
  logic [31:0] cpu_addr_i, cpu_data_i;
  logic [3:0]  cpu_mask_i;
  logic        dma_valid_i, dma_ready_o, dma_last_i;
  logic [31:0] dma_addr_i, dma_data_i;
  logic [3:0]  dma_mask_i;
  logic [31:0] mem_addr_o, mem_din_o;
  logic [3:0]  dmem_we_o, imem_we_o;
  logic        mmio_we_o, drop_err_o, grant_dma_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  mem_write_arbiter #(
    .MAX_BURST    (8),
    .STARVE_LIMIT (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_valid_i (cpu_valid_i),
    .cpu_ready_o (cpu_ready_o),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_mask_i  (cpu_mask_i),
    .dma_valid_i (dma_valid_i),
    .dma_ready_o (dma_ready_o),
    .dma_last_i  (dma_last_i),
    .dma_addr_i  (dma_addr_i),
    .dma_data_i  (dma_data_i),
    .dma_mask_i  (dma_mask_i),
    .mem_addr_o  (mem_addr_o),
    .mem_din_o   (mem_din_o),
    .dmem_we_o   (dmem_we_o),
    .imem_we_o   (imem_we_o),
    .mmio_we_o   (mmio_we_o),
    .drop_err_o  (drop_err_o),
    .grant_dma_o (grant_dma_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_valid_i = 1'b0; cpu_addr_i = 32'd0; cpu_data_i = 32'd0; cpu_mask_i = 4'd0;
    dma_valid_i = 1'b0; dma_last_i = 1'b0;  dma_addr_i = 32'd0; dma_data_i = 32'd0;
    dma_mask_i  = 4'd0;
  endtask

  task automatic cpu_drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    cpu_valid_i = 1'b1; cpu_addr_i = a; cpu_data_i = d; cpu_mask_i = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          waits;
    int          beats;
    int          idx;
    int          both;
    bit          cpu_done;
    logic [12:0] seq;

    idle_inputs();
    #1 rst_i = 1'b1;
    #11;
    chk("rst_dmem_we", 32'(dmem_we_o), 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_grant_dma", 32'(grant_dma_o), 32'h0);
    chk("rst_ready", 32'({cpu_ready_o, dma_ready_o}), 32'h0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    // CPU-only store to dmem.
    cpu_drive(32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("t1_cpu_ready", 32'(cpu_ready_o), 32'h1);
    chk("t1_dma_ready", 32'(dma_ready_o), 32'h0);
    tick();
    cpu_valid_i = 1'b0;
    chk("t1_mem_din", mem_din_o, 32'hDEAD_BEEF);
    chk("t1_mem_addr", mem_addr_o, 32'h1000_0004);
    chk("t1_dmem_we", 32'(dmem_we_o), 32'hF);
    chk("t1_imem_we", 32'(imem_we_o), 32'h0);
    tick();
    chk("t1_we_clear", 32'(dmem_we_o), 32'h0);
    chk("t1_din_hold", mem_din_o, 32'hDEAD_BEEF);

    // MMIO, drop, zero mask, dual target, back to back.
    cpu_drive(32'h8000_0008, 32'h0000_00AA, 4'b0001);
    tick();
    cpu_drive(32'h0000_0040, 32'h0000_00BB, 4'b1111);
    chk("t4_mmio_we", 32'(mmio_we_o), 32'h1);
    chk("t4_mmio_no_mem", 32'({dmem_we_o, imem_we_o}), 32'h0);
    chk("t4_mmio_addr", mem_addr_o, 32'h8000_0008);
    tick();
    cpu_drive(32'h1000_0000, 32'h0000_00CC, 4'b0000);
    chk("t4_drop_err", 32'(drop_err_o), 32'h1);
    chk("t4_drop_no_we", 32'({mmio_we_o, dmem_we_o, imem_we_o}), 32'h0);
    tick();
    cpu_drive(32'h3000_0000, 32'h1122_3344, 4'b0011);
    chk("t4_mask0_quiet", 32'({drop_err_o, mmio_we_o, dmem_we_o, imem_we_o}), 32'h0);
    chk("t4_mask0_addr", mem_addr_o, 32'h1000_0000);
    chk("t4_mask0_din", mem_din_o, 32'h0000_00CC);
    tick();
    cpu_valid_i = 1'b0;
    chk("t5_dual", 32'({dmem_we_o, imem_we_o}), 32'h33);
    chk("t5_dual_flags", 32'({mmio_we_o, drop_err_o}), 32'h0);
    tick();
    chk("t5_dual_clear", 32'({dmem_we_o, imem_we_o}), 32'h0);

    // Contention: CPU wins 16 times, then the starving DMA gets one beat.
    cpu_drive(32'h1000_0010, 32'h0000_0001, 4'hF);
    dma_valid_i = 1'b1; dma_last_i = 1'b1; dma_addr_i = 32'h2000_0000;
    dma_data_i  = 32'hA5A5_A5A5; dma_mask_i = 4'hF;
    #1;
    waits = 0;
    while (!dma_ready_o && waits < 40) begin
      tick(); #1;
      waits++;
    end
    chk("t2_starve_wait", 32'(waits), 32'd16);
    chk("t2_cpu_blocked", 32'(cpu_ready_o), 32'h0);
    tick();
    chk("t2_dma_addr", mem_addr_o, 32'h2000_0000);
    chk("t2_dma_imem", 32'(imem_we_o), 32'hF);
    chk("t2_dma_dmem", 32'(dmem_we_o), 32'h0);
    #1;
    chk("t2_cpu_back", 32'(cpu_ready_o), 32'h1);
    waits = 0;
    while (!dma_ready_o && waits < 40) begin
      tick(); #1;
      waits++;
    end
    chk("t2_starve_rewait", 32'(waits), 32'd16);
    tick();
    idle_inputs();
    chk("t2_no_grant_dma", 32'(grant_dma_o), 32'h0);
    tick();

    // 12-beat burst, CPU arrives at beat 3: expect D x8, C, D x4.
    seq = '0; idx = 0; beats = 0; both = 0; cpu_done = 1'b0;
    for (int cyc = 0; cyc < 40 && beats < 12; cyc++) begin
      dma_valid_i = 1'b1;
      dma_addr_i  = 32'h1000_0100 + 32'(beats * 4);
      dma_data_i  = 32'(beats);
      dma_mask_i  = 4'hF;
      dma_last_i  = (beats == 11);
      cpu_valid_i = (beats >= 2) && !cpu_done;
      cpu_addr_i  = 32'h1000_0200; cpu_data_i = 32'h0000_C0DE; cpu_mask_i = 4'hF;
      #1;
      if (cpu_ready_o && dma_ready_o) both++;
      if (dma_ready_o && idx < 13) begin
        seq[idx] = 1'b1; idx++; beats++;
      end else if (cpu_ready_o && idx < 13) begin
        seq[idx] = 1'b0; idx++; cpu_done = 1'b1;
      end
      tick();
    end
    idle_inputs();
    chk("t3_grant_seq", 32'(seq), 32'h1EFF);
    chk("t3_grant_count", 32'(idx), 32'd13);
    chk("t3_both_ready", 32'(both), 32'd0);
    chk("t3_last_addr", mem_addr_o, 32'h1000_012C);
    chk("t3_last_din", mem_din_o, 32'd11);
    chk("t3_to_idle", 32'(grant_dma_o), 32'h0);
    tick();

    // 10-beat burst without CPU: stays in burst across the MAX_BURST boundary.
    waits = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      dma_valid_i = 1'b1; dma_addr_i = 32'h1000_0300; dma_data_i = 32'(cyc);
      dma_mask_i  = 4'hF; dma_last_i = (cyc == 9);
      #1;
      if (dma_ready_o) waits++;
      if (cyc == 8) chk("t3b_hold_burst", 32'(grant_dma_o), 32'h1);
      tick();
    end
    idle_inputs();
    chk("t3b_beats", 32'(waits), 32'd10);
    chk("t3b_idle", 32'(grant_dma_o), 32'h0);
    tick();

    // Reset in the middle of a burst.
    for (int cyc = 0; cyc < 4; cyc++) begin
      dma_valid_i = 1'b1; dma_addr_i = 32'h1000_0400 + 32'(cyc * 4);
      dma_data_i  = 32'(cyc); dma_mask_i = 4'hF; dma_last_i = 1'b0;
      tick();
    end
    chk("t6_beat4_we", 32'(dmem_we_o), 32'hF);
    chk("t6_in_burst", 32'(grant_dma_o), 32'h1);
    cpu_drive(32'h2000_0020, 32'h0000_0055, 4'b1100);
    #3 rst_i = 1'b1;
    #1;
    chk("t6_rst_we", 32'({dmem_we_o, imem_we_o}), 32'h0);
    chk("t6_rst_addr", mem_addr_o, 32'h0);
    chk("t6_rst_state", 32'(grant_dma_o), 32'h0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    #1;
    chk("t6_cpu_first", 32'({cpu_ready_o, dma_ready_o}), 32'h2);
    tick();
    idle_inputs();
    chk("t6_cpu_addr", mem_addr_o, 32'h2000_0020);
    chk("t6_cpu_imem", 32'({dmem_we_o, imem_we_o}), 32'h0C);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_write_arbiter.md
Name: mem_write_arbiter

Overview:
- Shares the single data/instruction memory write port between two requesters: CPU store path (port 0) and the bulk-copy/DMA engine (port 1).
- Registers the winning beat and drives per-target byte write enables: dmem, imem, and the MMIO strobe.
- Sits between the store-alignment logic/DMA engine and the BRAMs/MMIO decode.
- CPU has priority; DMA gets bounded bursts and a starvation guarantee.

Parameters:
- MAX_BURST, 8, maximum consecutive DMA beats before DMA must yield to a waiting CPU (1..255).
- STARVE_LIMIT, 16, cycles DMA may wait with valid high before it is force-granted (1..255).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- cpu_valid  input  1  CPU store beat valid
- cpu_ready  output  1  CPU beat accepted this cycle
- cpu_addr  input  32  CPU byte address (word-aligned use of [31:2])
- cpu_data  input  32  CPU lane-aligned write data
- cpu_mask  input  4  CPU byte mask
- dma_valid  input  1  DMA beat valid
- dma_ready  output  1  DMA beat accepted this cycle
- dma_last  input  1  final beat of DMA burst (sampled only with dma_valid)
- dma_addr  input  32  DMA byte address
- dma_data  input  32  DMA write data
- dma_mask  input  4  DMA byte mask
- mem_addr  output  32  registered address of accepted beat
- mem_din  output  32  registered data of accepted beat
- dmem_we  output  4  registered mask if addr[28] set, else 0
- imem_we  output  4  registered mask if addr[29] set, else 0
- mmio_we  output  1  registered pulse if addr[31] set and mask nonzero
- drop_err  output  1  registered pulse: accepted beat hit no target (addr[31,29,28] all 0) with nonzero mask
- grant_dma  output  1  current owner is DMA (state DMA_BURST), for debug/perf counters

Behaviour:
- Reset (async, immediate): state IDLE; burst_cnt=0; starve_cnt=0; all registered outputs 0. cpu_ready/dma_ready are combinational from state and are 0 only for the loser.
- Handshake:
  - Beat transfers when valid&&ready.
  - ready is combinational from state/counters/valids. It never depends on the same port's data.
  - Exactly one of cpu_ready/dma_ready is high in a cycle, or neither.
- Latency: an accepted beat appears on mem_*/we outputs the next cycle for exactly one cycle. With no transfer, we outputs=0; mem_addr/mem_din hold.
- Target decode is on the registered beat:
  - addr[28] and addr[29] may both be set; both we vectors then assert.
  - addr[31] is exclusive: if set, dmem_we=imem_we=0.
  - mask=0 beat is accepted and consumes a burst slot, but produces no enables and no drop_err.
- States:
  - IDLE:
    - cpu_valid and not starving -> grant CPU, stay IDLE.
    - Otherwise dma_valid -> grant DMA; burst_cnt=1; go DMA_BURST unless dma_last.
  - DMA_BURST:
    - DMA holds the port; cpu_ready=0.
    - Each DMA beat increments burst_cnt.
    - Return to IDLE after a beat with dma_last=1.
    - Also return to IDLE after the beat that makes burst_cnt==MAX_BURST while cpu_valid=1; CPU then wins the next cycle.
    - If burst_cnt reaches MAX_BURST with cpu_valid=0, stay and reset burst_cnt to 0.
    - dma_valid low in DMA_BURST: no transfer, stay, counters hold.
- Starvation:
  - starve_cnt increments each cycle dma_valid=1 && dma_ready=0, saturating at STARVE_LIMIT.
  - It clears on any DMA accept or when dma_valid=0.
  - starving = (starve_cnt==STARVE_LIMIT). In IDLE, starving overrides CPU priority for one grant.
- Simultaneous events:
  - Both valid in IDLE, not starving -> CPU.
  - Both valid with dma_last on the final beat -> the DMA beat is accepted, then CPU is eligible the next cycle.
- Reset mid-burst: aborts ownership; no partial write emitted after rst rises; the DMA engine restarts its burst.
- No combinational path from mem outputs back to ready.

Decomposition:
- Shared package/header (alongside the opcode defines): address decode constants DMEM_SEL_BIT=28, IMEM_SEL_BIT=29, MMIO_SEL_BIT=31; state encoding ARB_IDLE/ARB_DMA_BURST.
- One natural sub-module: write_port_decode, a combinational mask/address -> dmem_we/imem_we/mmio_we/drop_err decode. It is reused by the load path, and its outputs are registered in this block.

Test Plan:
1. CPU only: cpu_valid, addr 0x10000004, data 0xDEADBEEF, mask 4'b1111 -> cpu_ready=1 same cycle; next cycle dmem_we=4'b1111, mem_din=0xDEADBEEF, imem_we=0.
2. Contention in IDLE: both valid, DMA addr 0x20000000 -> CPU granted. DMA waits until cpu_valid drops, or STARVE_LIMIT=16 cycles pass, then dma_ready=1 for one beat. starve_cnt returns to 0.
3. DMA burst of 12 beats, MAX_BURST=8, cpu_valid asserted at beat 3 -> 8 DMA beats, 1 CPU beat, then 4 DMA beats; dma_last on beat 12 -> IDLE.
4. MMIO / drop: addr 0x80000008 mask 0001 -> mmio_we pulse, no dmem/imem. Addr 0x00000040 mask 1111 -> drop_err pulse. Mask 0000 -> no pulses.
5. Dual target: addr 0x30000000 mask 0011 -> dmem_we=imem_we=4'b0011.
6. Reset asserted mid-burst (beat 4) between clock edges -> outputs 0 immediately, state IDLE; first cycle after release grants CPU if cpu_valid.
